mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the operand width; legal range is 2..63.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester N presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH bits each: operands.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 bit each: the operand pair is accepted when valid and ready are both high on a rising edge.
REQ-007 SHALL have port resp_valid, output, 1 bit: a product is available.
REQ-008 SHALL have port resp_id, output, 1 bit: the requester index that owns the product.
REQ-009 SHALL have port resp_product, output, 2*WIDTH bits: A*B, unsigned.
REQ-010 SHALL have port resp_ready, input, 1 bit: the consumer takes the product when resp_valid and resp_ready are both high.

Function
REQ-011 SHALL share one sequential shift-add multiplier between two requesters, one operation in flight at a time.
REQ-012 SHALL implement an FSM with three states:
- IDLE: multiplier start low.
- RUN: start high, cycle counter active.
- RESP: start high, product held.
REQ-013 SHALL arbitrate in IDLE when at least one valid is high:
- Only one valid high: that requester is granted.
- Both high: the requester not granted last time wins (round-robin).
REQ-014 SHALL drive reqN_ready combinationally: high only in IDLE and only for the granted requester; at most one ready is high per cycle.
REQ-015 SHALL act on the accepting edge: latch the operands and the grant index into internal registers, update last_grant, clear the counter, and go to RUN.
REQ-016 SHALL, in RUN, hold the multiplier start high with the latched operands and increment the counter each cycle.
REQ-017 SHALL, when the counter reaches WIDTH+2 (multiplier load, WIDTH iterations, output register), capture the multiplier output into resp_product, set resp_valid, and go to RESP.
REQ-018 SHALL raise resp_valid exactly WIDTH+3 cycles after the accepting edge, with no other variation in latency.
REQ-019 SHALL hold resp_valid, resp_id and resp_product stable in RESP until resp_ready is high.
REQ-020 SHALL, on the handshake edge in RESP, clear resp_valid and go to IDLE; start then drops for at least one cycle, which clears the multiplier before the next operation.
REQ-021 SHALL ignore requests arriving during RUN or RESP; they wait with ready low and are not lost.
REQ-022 SHALL NOT accept a new request in the same cycle as the resp handshake; the earliest next accept is one cycle later.
REQ-023 SHALL produce the correct full-width product for operands of 0, 1 and all-ones; for example all-ones squared is (2^WIDTH-1)^2 with no truncation.
REQ-024 SHALL NOT let a change in reqN_a/reqN_b after acceptance affect the in-flight product.

Reset
REQ-025 SHALL, when rst is high on a rising edge, set:
- state to IDLE,
- resp_valid, resp_id and resp_product to 0,
- counter and latched operands to 0,
- last_grant to 1, so req0 wins the first tie.
REQ-026 SHALL treat reset as dominant in any state; reset mid-RUN or mid-RESP abandons the operation with no response produced, and start is low in the following cycle.
REQ-027 SHALL hold reqN_ready low while rst is high.

Structure
REQ-028 SHALL place the state encoding (IDLE, RUN, RESP) and the latency constant WIDTH+2 in a shared package, mult_pkg.
REQ-029 SHALL instantiate exactly one sub-module, multiplier, with WIDTH passed through and start, A and B driven from the FSM and latched operands.
REQ-030 SHALL size the counter to 6 bits, consistent with the multiplier's iteration counter.

Verification
REQ-031 SHALL cover single request (WIDTH=4): req0 valid, a=3, b=5 -> ready high in the accept cycle, resp_valid 7 cycles later, resp_id=0, resp_product=15.
REQ-032 SHALL cover a tie after reset (WIDTH=4): both valid from reset release, req0 a=2,b=7, req1 a=15,b=15 -> req0 served first with 14, then req1 with 225; ready never high on both.
REQ-033 SHALL cover backpressure (WIDTH=4): resp_ready held low 5 cycles after resp_valid -> outputs stable for all 5 cycles; handshake -> IDLE, next accept no earlier than 1 cycle after.
REQ-034 SHALL cover round-robin (WIDTH=4): req0 and req1 continuously valid for 4 operations -> grant order 0,1,0,1.
REQ-035 SHALL cover reset mid-RUN (WIDTH=4): rst pulsed 3 cycles after accept -> no resp_valid, outputs 0; a fresh request afterwards returns the correct product.
REQ-036 SHALL cover operand change in flight (WIDTH=4): req0_a changed from 9 to 1 after accept, with b=9 -> product 81.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the two-port arbitrated multiplier.
// Holds the FSM encoding and the response latency helper.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int CNT_W     = 6;
  localparam int LAT_EXTRA = 2;

  // Load + WIDTH iterations + output register; kept modulo the counter width
  function automatic logic [CNT_W-1:0] lat_cnt(input int width);
    int l;
    l = width + LAT_EXTRA;
    return l[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/multiplier.sv
// Sequential shift-add unsigned multiplier: one load cycle, WIDTH
// iterations, one output register cycle. Dropping start clears it.
module multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_done
);

  localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH);

  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_iter;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_prod;

  always_ff @(posedge clk) begin
    if (rst || !i_start) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_iter   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
    end else if (!r_busy) begin
      r_busy   <= 1'b1;
      r_iter   <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_iter != ITERS) begin
      if (r_mplier[0])
        r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_iter   <= r_iter + CNT_W'(1);
    end else if (!r_done) begin
      r_prod <= r_acc;
      r_done <= 1'b1;
    end
  end

  assign o_product = r_prod;
  assign o_done    = r_done;

endmodule

// File: rtl/mult_arbiter.sv
// Two requesters share one sequential multiplier; round-robin on ties,
// one operation in flight, fixed WIDTH+3 cycle accept-to-response latency.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [2*WIDTH-1:0] resp_product,
  input  logic               resp_ready
);

  localparam logic [CNT_W-1:0] LAT = lat_cnt(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic               r_last;
  logic               r_id;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_resp_valid;
  logic               r_resp_id;
  logic [2*WIDTH-1:0] r_resp_prod;

  logic               w_grant;
  logic               w_any;
  logic               w_idle;
  logic               w_accept;
  logic               w_start;
  logic               w_done;
  logic               w_fire;
  logic               w_resp_hs;
  logic [2*WIDTH-1:0] w_prod;

  always_comb begin
    w_grant = 1'b0;
    unique case (1'b1)
      (req0_valid && req1_valid):  w_grant = ~r_last;
      (!req0_valid && req1_valid): w_grant = 1'b1;
      default:                     w_grant = 1'b0;
    endcase
  end

  assign w_any      = req0_valid | req1_valid;
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_accept   = w_idle && w_any;
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept && w_grant;

  assign w_start   = (r_state != S_IDLE);
  // done gates the compare so a wrapped counter cannot fire early
  assign w_fire    = (r_state == S_RUN) && (r_cnt == LAT) && w_done;
  assign w_resp_hs = (r_state == S_RESP) && resp_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)   w_next = S_RUN;
      S_RUN:   if (w_fire)     w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_prod  <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= w_grant ? req1_a : req0_a;
        r_b    <= w_grant ? req1_b : req0_b;
        r_id   <= w_grant;
        r_last <= w_grant;
        r_cnt  <= '0;
      end
      if ((r_state == S_RUN) && !w_fire)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_id    <= r_id;
        r_resp_prod  <= w_prod;
      end
      if (w_resp_hs)
        r_resp_valid <= 1'b0;
    end
  end

  multiplier #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_product(w_prod),
    .o_done   (w_done)
  );

  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_product = r_resp_prod;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter at WIDTH=4.
module tb_mult_arbiter;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid, req1_valid;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic           resp_valid, resp_id, resp_ready;
  logic [2*W-1:0] resp_product;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_product(resp_product),
    .resp_ready  (resp_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst && (req0_ready || req1_ready))
      check("ready_excl", 64'(req0_ready & req1_ready), 64'd0);

  // Caller is in IDLE with the request presented; new_a replaces the
  // accepted requester's A right after acceptance when drop is set.
  task automatic run_op(input string tag, input logic id,
                        input logic [7:0] prod, input bit drop,
                        input logic [W-1:0] new_a);
    int lat;
    check({tag, "_rdy"}, 64'(id ? req1_ready : req0_ready), 64'd1);
    check({tag, "_nrdy"}, 64'(id ? req0_ready : req1_ready), 64'd0);
    tick();
    if (drop) begin
      if (id) begin req1_valid = 1'b0; req1_a = new_a; end
      else    begin req0_valid = 1'b0; req0_a = new_a; end
    end
    lat = 0;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(W + 3));
    check({tag, "_id"}, 64'(resp_id), 64'(id));
    check({tag, "_prod"}, 64'(resp_product), 64'(prod));
    tick();
    check({tag, "_clr"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin : main
    int lat;
    bit saw;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd2;  req0_b = 4'd7;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
    repeat (3) tick();
    check("rst_rdy0", 64'(req0_ready), 64'd0);
    check("rst_rdy1", 64'(req1_ready), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_id", 64'(resp_id), 64'd0);
    check("rst_prod", 64'(resp_product), 64'd0);

    rst = 1'b0;
    #1;
    run_op("tie0", 1'b0, 8'd14, 1'b1, 4'd3);
    run_op("tie1", 1'b1, 8'd225, 1'b1, 4'd0);

    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd7;
    #1;
    run_op("rr0", 1'b0, 8'd15, 1'b0, 4'd0);
    run_op("rr1", 1'b1, 8'd42, 1'b0, 4'd0);
    run_op("rr2", 1'b0, 8'd15, 1'b0, 4'd0);
    run_op("rr3", 1'b1, 8'd42, 1'b0, 4'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    #1;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    #1;
    run_op("single", 1'b0, 8'd15, 1'b1, 4'd12);
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd15;
    #1;
    run_op("zero", 1'b0, 8'd0, 1'b1, 4'd7);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd15;
    #1;
    run_op("one", 1'b0, 8'd15, 1'b1, 4'd7);

    req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4;
    resp_ready = 1'b0;
    #1;
    check("bp_rdy", 64'(req0_ready), 64'd1);
    tick();
    req0_a = 4'd5; req0_b = 4'd3;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_lat", 64'(lat), 64'(W + 3));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_id", 64'(resp_id), 64'd0);
      check("bp_prod", 64'(resp_product), 64'd16);
      check("bp_wait", 64'(req0_ready), 64'd0);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_hs_rdy", 64'(req0_ready), 64'd0);
    tick();
    check("bp_hs_clr", 64'(resp_valid), 64'd0);
    run_op("bp_next", 1'b0, 8'd15, 1'b1, 4'd0);

    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd3;
    #1;
    check("mid_rdy", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_valid", 64'(resp_valid), 64'd0);
    check("mid_id", 64'(resp_id), 64'd0);
    check("mid_prod", 64'(resp_product), 64'd0);
    saw = 1'b0;
    repeat (12) begin
      tick();
      if (resp_valid) saw = 1'b1;
    end
    check("mid_noresp", 64'(saw), 64'd0);
    req0_valid = 1'b1; req0_a = 4'd11; req0_b = 4'd13;
    #1;
    run_op("mid_fresh", 1'b0, 8'd143, 1'b1, 4'd2);

    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9;
    #1;
    run_op("inflight", 1'b0, 8'd81, 1'b1, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
